// File: rtl/frac_clk_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
// Lock FSM states, default widths and an increment calculator.
package frac_clk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LOCKED
  } lock_state_t;

  localparam int ACC_WIDTH_DEFAULT = 32;

  // round(f_out * 2^acc_width / f_ref), usable in constant expressions
  function automatic logic [63:0] calc_inc(
    input logic [63:0] f_out_hz,
    input logic [63:0] f_ref_hz,
    input int          acc_width
  );
    logic [127:0] num;
    num = ({64'd0, f_out_hz} << acc_width)
        + {65'd0, f_ref_hz[63:1]};
    return 64'(num / {64'd0, f_ref_hz});
  endfunction

endpackage

// File: rtl/frac_clk_gen_if.sv
// Reconfiguration handshake bundle: channel select plus new increment.
// Master drives the request, slave answers with ready.
interface frac_clk_gen_if
  import frac_clk_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEFAULT
);

  logic                 valid;
  logic                 ready;
  logic [2:0]           chan;
  logic [ACC_WIDTH-1:0] inc;

  modport master (
    output valid,
    output chan,
    output inc,
    input  ready
  );

  modport slave (
    input  valid,
    input  chan,
    input  inc,
    output ready
  );

endinterface

// File: rtl/frac_clk_chan.sv
// One phase-accumulator channel with increment register.
// Emits a registered carry strobe and a registered copy of the acc MSB.
module frac_clk_chan #(
  parameter int                   ACC_WIDTH = 32,
  parameter logic [ACC_WIDTH-1:0] INIT_INC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clear,
  input  logic [ACC_WIDTH-1:0] new_inc,
  output logic                 en,
  output logic                 sq
);

  logic [ACC_WIDTH-1:0] inc;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};

  // accumulate, reload increment on demand, clear phase on reconfig
  always_ff @(posedge clk) begin
    if (rst) begin
      inc <= INIT_INC;
      acc <= '0;
      en  <= 1'b0;
      sq  <= 1'b0;
    end else begin
      sq <= acc[ACC_WIDTH-1];
      if (load) begin
        inc <= new_inc;
      end
      if (clear) begin
        acc <= '0;
        en  <= 1'b0;
      end else begin
        acc <= sum[ACC_WIDTH-1:0];
        en  <= sum[ACC_WIDTH];
      end
    end
  end

endmodule

// File: rtl/frac_clk_gen.sv
// Multi-channel fractional clock-enable generator with lock indication.
// Holds the lock FSM, settle counter, cfg decode and output gating.
module frac_clk_gen
  import frac_clk_pkg::*;
#(
  parameter int                   NUM_CLOCKS  = 2,
  parameter int                   ACC_WIDTH   = ACC_WIDTH_DEFAULT,
  parameter logic [ACC_WIDTH-1:0] INIT_INC    =
    ACC_WIDTH'(64'd1030792151),
  parameter int                   LOCK_CYCLES = 1024
) (
  input  logic                  refclk,
  input  logic                  rst,
  frac_clk_gen_if.slave         cfg,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic [NUM_CLOCKS-1:0] outclk_sq,
  output logic                  locked
);

  localparam int CW = $clog2(LOCK_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_CYCLES - 1);

  lock_state_t           state;
  logic [CW-1:0]         cnt;
  logic                  take;
  logic                  hit;
  logic [NUM_CLOCKS-1:0] load;
  logic [NUM_CLOCKS-1:0] en;
  logic [NUM_CLOCKS-1:0] sq;

  assign cfg.ready = (state != IDLE);
  assign take      = cfg.valid && cfg.ready;
  assign hit       = take
                  && ({29'd0, cfg.chan} < 32'(NUM_CLOCKS));

  // lock FSM: any in-range reconfig restarts the settle window
  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= SETTLE;
          cnt   <= '0;
        end
        SETTLE: begin
          if (hit) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= LOCKED;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (hit) begin
            state <= SETTLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
    assign load[i] = hit && (cfg.chan == 3'(i));

    frac_clk_chan #(
      .ACC_WIDTH (ACC_WIDTH),
      .INIT_INC  (INIT_INC)
    ) u_chan (
      .clk     (refclk),
      .rst     (rst),
      .load    (load[i]),
      .clear   (hit),
      .new_inc (cfg.inc),
      .en      (en[i]),
      .sq      (sq[i])
    );
  end

  assign locked    = (state == LOCKED);
  assign outclk_en = en & {NUM_CLOCKS{locked}};
  assign outclk_sq = sq & {NUM_CLOCKS{locked}};

endmodule

// File: tb/tb_frac_clk_gen.sv
// Randomized bench for frac_clk_gen against an arithmetic reference model.
// Model tracks phase as integers and lock as edges since last restart.
module tb_frac_clk_gen;
  import frac_clk_pkg::*;

  localparam int NC = 2;
  localparam int AW = 32;
  localparam int LC = 16;
  localparam logic [AW-1:0] II = 32'd1030792151;
  localparam longint unsigned MOD = 64'd1 << AW;

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic [NC-1:0] outclk_en;
  logic [NC-1:0] outclk_sq;
  logic          locked;

  frac_clk_gen_if #(.ACC_WIDTH(AW)) cfg ();

  frac_clk_gen #(
    .NUM_CLOCKS  (NC),
    .ACC_WIDTH   (AW),
    .INIT_INC    (II),
    .LOCK_CYCLES (LC)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg       (cfg),
    .outclk_en (outclk_en),
    .outclk_sq (outclk_sq),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  longint unsigned m_inc [NC];
  longint unsigned m_acc [NC];
  bit              m_en  [NC];
  bit              m_sq  [NC];
  int              since;

  int n_err = 0;
  int n_chk = 0;
  int cnt_en [NC];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(bit r, bit v, int ch, longint unsigned inc);
    longint unsigned s;
    bit ok;
    if (r) begin
      for (int i = 0; i < NC; i++) begin
        m_inc[i] = 64'(II);
        m_acc[i] = 0;
        m_en[i]  = 0;
        m_sq[i]  = 0;
      end
      since = -1;
    end else begin
      ok = v && (since >= 0) && (ch < NC);
      for (int i = 0; i < NC; i++)
        m_sq[i] = ((m_acc[i] >> (AW - 1)) & 1) != 0;
      if (ok) begin
        m_inc[ch] = inc % MOD;
        for (int i = 0; i < NC; i++) begin
          m_acc[i] = 0;
          m_en[i]  = 0;
        end
        since = 0;
      end else begin
        for (int i = 0; i < NC; i++) begin
          s = m_acc[i] + m_inc[i];
          m_en[i]  = (s >= MOD);
          m_acc[i] = s % MOD;
        end
        if (since < 0) since = 0;
        else if (since < 100000) since++;
      end
    end
  endtask

  task automatic cyc(bit r, bit v, int ch, longint unsigned inc);
    logic [NC-1:0] e;
    logic [NC-1:0] s;
    bit lk;
    rst       = r;
    cfg.valid = v;
    cfg.chan  = ch[2:0];
    cfg.inc   = inc[AW-1:0];
    @(posedge refclk);
    model_edge(r, v, ch, inc);
    #1;
    cfg.valid = 1'b0;
    lk = (since >= LC);
    for (int i = 0; i < NC; i++) begin
      e[i] = lk & m_en[i];
      s[i] = lk & m_sq[i];
      cnt_en[i] += int'(outclk_en[i]);
    end
    chk("locked", 64'(locked), 64'(lk));
    chk("ready", 64'(cfg.ready), 64'(since >= 0));
    chk("en", 64'(outclk_en), 64'(e));
    chk("sq", 64'(outclk_sq), 64'(s));
  endtask

  task automatic idle(int n);
    repeat (n) cyc(0, 0, 0, 0);
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < NC; i++) cnt_en[i] = 0;
  endtask

  task automatic wait_lock(string tag);
    int n = 0;
    while (locked !== 1'b1 && n < 200) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    chk(tag, 64'(n), 64'(LC));
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sqacc;
    int ch;
    longint unsigned inc;
    bit r;
    cfg.valid = 1'b0;
    cfg.chan  = '0;
    cfg.inc   = '0;
    since     = -1;
    clr_cnt();

    chk("calc_inc",
        calc_inc(64'd12000000, 64'd50000000, 32), 64'd1030792151);

    repeat (3) cyc(1, 0, 0, 0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_ready", 64'(cfg.ready), 64'd0);
    cyc(0, 0, 0, 0);
    wait_lock("lock_pwr");

    clr_cnt();
    idle(50000);
    chk("rate0", 64'(cnt_en[0] >= 11999 && cnt_en[0] <= 12001), 64'd1);
    chk("rate1", 64'(cnt_en[1] >= 11999 && cnt_en[1] <= 12001), 64'd1);

    chk("rdy_pre", 64'(cfg.ready), 64'd1);
    cyc(0, 1, 1, 64'h8000_0000);
    chk("unlk_cfg", 64'(locked), 64'd0);
    wait_lock("lock_cfg");
    clr_cnt();
    idle(20);
    chk("ch1_half", 64'(cnt_en[1]), 64'd10);

    cyc(0, 1, 0, 0);
    wait_lock("lock_stop");
    clr_cnt();
    sqacc = 0;
    for (int k = 0; k < 1000; k++) begin
      cyc(0, 0, 0, 0);
      sqacc += int'(outclk_sq[0]);
    end
    chk("ch0_en_stop", 64'(cnt_en[0]), 64'd0);
    chk("ch0_sq_stop", 64'(sqacc), 64'd0);
    chk("ch1_run", 64'(cnt_en[1]), 64'd500);

    chk("rdy_oor", 64'(cfg.ready), 64'd1);
    cyc(0, 1, 5, 123);
    chk("lk_oor", 64'(locked), 64'd1);
    idle(10);

    cyc(0, 1, 0, 64'(II));
    idle(4);
    cyc(0, 1, 1, 777777);
    idle(4);
    cyc(0, 1, 0, 64'(II));
    wait_lock("lock_b2b");
    idle(50);

    repeat (40) begin
      r  = ($urandom_range(0, 15) == 0);
      ch = $urandom_range(0, 7);
      case ($urandom_range(0, 2))
        0:       inc = 64'($urandom());
        1:       inc = 64'($urandom_range(0, 4096));
        default: inc = 64'h8000_0000 + 64'($urandom_range(0, 1000));
      endcase
      cyc(r, 1, ch, inc);
      idle($urandom_range(0, 30));
    end

    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    wait_lock("lock_clean");
    cyc(0, 1, 1, 99999);
    idle(5);
    cyc(1, 1, 0, 12345);
    chk("col_locked", 64'(locked), 64'd0);
    chk("col_ready", 64'(cfg.ready), 64'd0);
    chk("col_en", 64'(outclk_en), 64'd0);
    chk("col_sq", 64'(outclk_sq), 64'd0);
    cyc(0, 0, 0, 0);
    wait_lock("lock_rst2");
    clr_cnt();
    idle(5000);
    chk("rate0_rst", 64'(cnt_en[0] >= 1199 && cnt_en[0] <= 1201), 64'd1);
    chk("rate1_rst", 64'(cnt_en[1] >= 1199 && cnt_en[1] <= 1201), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
